// File: rtl/ctrl_resolve_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_resolve_pkg
// Shared definitions for the control-resolve stage of the branch execution lane.
//   - EXECUTION_FLAGS width and the bit positions the stage decodes
//   - branch-predictor training packet layout
//   - resolve-stage FSM state encoding
// -----------------------------------------------------------------------------
package ctrl_resolve_pkg;

   localparam int EXEC_FLAGS_W = 8;

   localparam int MISPRED_BIT  = 0;
   localparam int EXEC_BIT     = 2;
   localparam int BPUPD_BIT    = 5;
   localparam int CTRL_BIT     = 7;

   // Default PC width of the lane; the training packet below uses it.
   localparam int BP_PC_W      = 32;

   // Training packet, MSB first. The FIFO stores this exact field order.
   typedef struct packed {
      logic [BP_PC_W-1:0] pc;
      logic [BP_PC_W-1:0] target;
      logic               dir;
   } bp_upd_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_DRAIN    = 2'd2
   } state_t;

   // Packed width of a training packet for an arbitrary PC width.
   function automatic int bp_upd_width(input int pc_w);
      return 2 * pc_w + 1;
   endfunction

endpackage

// File: rtl/ctrl_resolve_stage_bp_update_fifo.sv
// -----------------------------------------------------------------------------
// bp_update_fifo
// Small synchronous FIFO holding branch-predictor training packets.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   i_push/i_data  write request and payload (dropped when full with no pop)
//   i_pop          read request (ignored when empty)
//   o_data         head entry, forced to zero while empty
//   o_empty        no entries held
//   o_count_next   occupancy after the current edge
// -----------------------------------------------------------------------------
module bp_update_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 65,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic [CW-1:0]    o_count_next
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_full;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_pop   = i_pop & ~o_empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign w_push  = i_push & (~w_full | w_pop);

   always_comb begin
      o_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   o_count_next = r_count + CW'(1);
         2'b01:   o_count_next = r_count - CW'(1);
         default: o_count_next = r_count;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH.
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= o_count_next;
      end
   end

   // NOTE: storage has no reset; validity is tracked by the count, and the
   // read mux below zeroes the output while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/ctrl_resolve_stage.sv
// -----------------------------------------------------------------------------
// ctrl_resolve_stage
// Registered resolution stage behind the control ALU. Latches one resolved
// control instruction per cycle, presents its writeback, raises a one-cycle
// front-end redirect on a mispredict, suppresses wrong-path packets for a
// fixed window, and queues predictor training packets.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   exeValid_i, pc_i, result_i,     resolved packet from the control ALU
//   nextPC_i, direction_i, flags_i,
//   destValid_i, phyDest_i, robID_i
//   flush_i                         commit-side squash
//   wb*_o                           registered writeback to ROB/register file
//   recoverValid_o, recoverPC_o     front-end redirect pulse and target
//   updValid_o, updReady_i,         predictor training handshake
//   updPC_o, updTarget_o, updDir_o
//   stall_o                         upstream must stop issuing
// -----------------------------------------------------------------------------
module ctrl_resolve_stage
   import ctrl_resolve_pkg::*;
#(
   parameter int SIZE_PC           = 32,
   parameter int SIZE_ROB_LOG      = 7,
   parameter int SIZE_PHYSICAL_LOG = 7,
   parameter int UPD_DEPTH         = 4,
   parameter int DRAIN_CYCLES      = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         exeValid_i,
   input  logic [SIZE_PC-1:0]           pc_i,
   input  logic [SIZE_PC-1:0]           result_i,
   input  logic [SIZE_PC-1:0]           nextPC_i,
   input  logic                         direction_i,
   input  logic [EXEC_FLAGS_W-1:0]      flags_i,
   input  logic                         destValid_i,
   input  logic [SIZE_PHYSICAL_LOG-1:0] phyDest_i,
   input  logic [SIZE_ROB_LOG-1:0]      robID_i,
   input  logic                         flush_i,
   output logic                         wbValid_o,
   output logic                         wbDestValid_o,
   output logic                         wbMispredict_o,
   output logic [SIZE_PC-1:0]           wbData_o,
   output logic [SIZE_PHYSICAL_LOG-1:0] wbPhyDest_o,
   output logic [SIZE_ROB_LOG-1:0]      wbRobID_o,
   output logic                         recoverValid_o,
   output logic [SIZE_PC-1:0]           recoverPC_o,
   output logic                         updValid_o,
   input  logic                         updReady_i,
   output logic [SIZE_PC-1:0]           updPC_o,
   output logic [SIZE_PC-1:0]           updTarget_o,
   output logic                         updDir_o,
   output logic                         stall_o
);

   localparam int CNT_W  = $clog2(DRAIN_CYCLES + 1);
   localparam int UPD_W  = bp_upd_width(SIZE_PC);
   localparam int UPD_CW = $clog2(UPD_DEPTH) + 1;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [CNT_W-1:0]        r_drain_cnt;
   logic [CNT_W-1:0]        w_drain_cnt_next;

   logic                    w_accept;
   logic                    w_mispred;
   logic                    w_upd_push;
   logic                    w_upd_pop;
   logic                    w_upd_empty;
   logic [UPD_W-1:0]        w_upd_wdata;
   logic [UPD_W-1:0]        w_upd_head;
   logic [UPD_CW-1:0]       w_upd_count_next;
   logic                    w_stall_next;
   logic                    w_flags_unused;

   logic                         r_wb_valid;
   logic                         r_wb_dest_valid;
   logic                         r_wb_mispred;
   logic [SIZE_PC-1:0]           r_wb_data;
   logic [SIZE_PHYSICAL_LOG-1:0] r_wb_phy_dest;
   logic [SIZE_ROB_LOG-1:0]      r_wb_rob_id;
   logic [SIZE_PC-1:0]           r_recover_pc;
   logic                         r_stall;

   // Only executed packets are resolved; anything arriving outside IDLE is
   // wrong-path, and a squash discards the packet in its own cycle.
   assign w_accept   = exeValid_i & flags_i[EXEC_BIT] & (r_state == ST_IDLE) & ~flush_i;
   assign w_mispred  = flags_i[MISPRED_BIT];
   assign w_upd_push = w_accept & flags_i[BPUPD_BIT];
   assign w_upd_pop  = updValid_o & updReady_i;

   // Remaining flag bits are informational for this stage.
   assign w_flags_unused = ^{flags_i[CTRL_BIT], flags_i[6], flags_i[4:3], flags_i[1]};

   // ---------------------------------------------------------------------------
   // Redirect / drain FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_next     = r_state;
      w_drain_cnt_next = r_drain_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && w_mispred) w_state_next = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            w_state_next     = ST_DRAIN;
            w_drain_cnt_next = CNT_W'(DRAIN_CYCLES - 1);
         end
         ST_DRAIN: begin
            if (r_drain_cnt == '0) w_state_next = ST_IDLE;
            else                   w_drain_cnt_next = r_drain_cnt - CNT_W'(1);
         end
         default: w_state_next = ST_IDLE;
      endcase
      // A squash abandons any redirect in progress; accept is already blocked.
      if (flush_i) w_state_next = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_state_next;
         r_drain_cnt <= w_drain_cnt_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage register: writeback, redirect target, stall
   // ---------------------------------------------------------------------------
   // Stall looks at post-edge occupancy and state so upstream sees it one
   // cycle earlier than a registered-from-current version would allow.
   assign w_stall_next = (w_upd_count_next >= UPD_CW'(UPD_DEPTH - 1)) |
                         (w_state_next != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wb_valid      <= 1'b0;
         r_wb_dest_valid <= 1'b0;
         r_wb_mispred    <= 1'b0;
         r_wb_data       <= '0;
         r_wb_phy_dest   <= '0;
         r_wb_rob_id     <= '0;
         r_recover_pc    <= '0;
         r_stall         <= 1'b0;
      end else begin
         r_wb_valid <= w_accept;
         r_stall    <= w_stall_next;
         if (w_accept) begin
            r_wb_dest_valid <= destValid_i;
            r_wb_mispred    <= w_mispred;
            r_wb_data       <= result_i;
            r_wb_phy_dest   <= phyDest_i;
            r_wb_rob_id     <= robID_i;
         end
         // Target is held after the pulse until the next mispredict.
         if (w_accept && w_mispred) r_recover_pc <= nextPC_i;
      end
   end

   assign wbValid_o      = r_wb_valid;
   assign wbDestValid_o  = r_wb_dest_valid;
   assign wbMispredict_o = r_wb_mispred;
   assign wbData_o       = r_wb_data;
   assign wbPhyDest_o    = r_wb_phy_dest;
   assign wbRobID_o      = r_wb_rob_id;
   assign recoverValid_o = (r_state == ST_REDIRECT);
   assign recoverPC_o    = r_recover_pc;
   assign stall_o        = r_stall;

   // ---------------------------------------------------------------------------
   // Predictor training FIFO
   // ---------------------------------------------------------------------------
   // Field order matches bp_upd_t: {pc, target, dir}.
   assign w_upd_wdata = {pc_i, nextPC_i, direction_i};

   bp_update_fifo #(
      .DEPTH (UPD_DEPTH),
      .WIDTH (UPD_W)
   ) u_bp_update_fifo (
      .clk          (clk),
      .reset        (reset),
      .i_push       (w_upd_push),
      .i_data       (w_upd_wdata),
      .i_pop        (w_upd_pop),
      .o_data       (w_upd_head),
      .o_empty      (w_upd_empty),
      .o_count_next (w_upd_count_next)
   );

   // updValid_o and the head data come from registers only, so updReady_i
   // never reaches an output combinationally.
   assign updValid_o  = ~w_upd_empty;
   assign updPC_o     = w_upd_head[UPD_W-1 -: SIZE_PC];
   assign updTarget_o = w_upd_head[SIZE_PC:1];
   assign updDir_o    = w_upd_head[0];

endmodule

// File: tb/tb_ctrl_resolve_stage.sv
// -----------------------------------------------------------------------------
// tb_ctrl_resolve_stage
// Scoreboard bench: the driver computes expected writebacks, redirects and
// training packets from a cycle-level reference model and queues them; the
// monitor compares DUT outputs against the queues on the falling edge.
// -----------------------------------------------------------------------------
module tb_ctrl_resolve_stage;
   import ctrl_resolve_pkg::*;

   localparam int PCW   = 32;
   localparam int ROBW  = 7;
   localparam int PHYW  = 7;
   localparam int DEPTH = 4;
   localparam int DRAIN = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic            exeValid_i;
   logic [PCW-1:0]  pc_i, result_i, nextPC_i;
   logic            direction_i;
   logic [7:0]      flags_i;
   logic            destValid_i;
   logic [PHYW-1:0] phyDest_i;
   logic [ROBW-1:0] robID_i;
   logic            flush_i;
   logic            wbValid_o, wbDestValid_o, wbMispredict_o;
   logic [PCW-1:0]  wbData_o;
   logic [PHYW-1:0] wbPhyDest_o;
   logic [ROBW-1:0] wbRobID_o;
   logic            recoverValid_o;
   logic [PCW-1:0]  recoverPC_o;
   logic            updValid_o, updReady_i;
   logic [PCW-1:0]  updPC_o, updTarget_o;
   logic            updDir_o;
   logic            stall_o;

   always #5 clk = ~clk;

   ctrl_resolve_stage #(
      .SIZE_PC(PCW), .SIZE_ROB_LOG(ROBW), .SIZE_PHYSICAL_LOG(PHYW),
      .UPD_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)
   ) dut (
      .clk(clk), .reset(reset), .exeValid_i(exeValid_i), .pc_i(pc_i),
      .result_i(result_i), .nextPC_i(nextPC_i), .direction_i(direction_i),
      .flags_i(flags_i), .destValid_i(destValid_i), .phyDest_i(phyDest_i),
      .robID_i(robID_i), .flush_i(flush_i), .wbValid_o(wbValid_o),
      .wbDestValid_o(wbDestValid_o), .wbMispredict_o(wbMispredict_o),
      .wbData_o(wbData_o), .wbPhyDest_o(wbPhyDest_o), .wbRobID_o(wbRobID_o),
      .recoverValid_o(recoverValid_o), .recoverPC_o(recoverPC_o),
      .updValid_o(updValid_o), .updReady_i(updReady_i), .updPC_o(updPC_o),
      .updTarget_o(updTarget_o), .updDir_o(updDir_o), .stall_o(stall_o)
   );

   typedef struct {
      logic            exe;
      logic [PCW-1:0]  pc, res, npc;
      logic            dir;
      logic [7:0]      flags;
      logic            dv;
      logic [PHYW-1:0] pd;
      logic [ROBW-1:0] rob;
      logic            flush, rdy, rst;
   } stim_t;

   typedef struct {
      int              cyc;
      logic [PCW-1:0]  data;
      logic            dv;
      logic [PHYW-1:0] pd;
      logic [ROBW-1:0] rob;
      logic            mp;
   } wb_exp_t;

   typedef struct {
      int             cyc;
      logic [PCW-1:0] pc;
   } rd_exp_t;

   wb_exp_t   wb_q[$];
   rd_exp_t   rd_q[$];
   bp_upd_t   upd_q[$];      // model of the training FIFO contents
   int        wrong_left = 0; // cycles of wrong-path window still to run
   logic [PCW-1:0] m_rpc = '0;

   int    cyc = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   bit    mon_en = 1'b0;
   stim_t cur;
   bit    cur_acc = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic stim_t idle(input logic rdy);
      stim_t s = '{default: '0};
      s.rdy = rdy;
      return s;
   endfunction

   function automatic stim_t mk(input logic [PCW-1:0] pc, input logic [PCW-1:0] res,
                                input logic [PCW-1:0] npc, input logic dir,
                                input logic [7:0] flags, input logic dv, input logic rdy);
      stim_t s = idle(rdy);
      s.exe = 1'b1; s.pc = pc; s.res = res; s.npc = npc; s.dir = dir;
      s.flags = flags; s.dv = dv;
      s.pd  = pc[8:2];
      s.rob = pc[10:4] ^ 7'h2A;
      return s;
   endfunction

   // Apply the architectural effect of the previous cycle's inputs at the edge.
   task automatic apply_model();
      if (cur.rst) begin
         upd_q.delete();
         wrong_left = 0;
         m_rpc = '0;
      end else begin
         if (cur_acc && cur.flags[5] && upd_q.size() < DEPTH)
            upd_q.push_back('{pc: cur.pc, target: cur.npc, dir: cur.dir});
         if (cur_acc && cur.flags[0]) begin
            wrong_left = DRAIN + 1;
            m_rpc = cur.npc;
         end else if (cur.flush) begin
            wrong_left = 0;
         end else if (wrong_left > 0) begin
            wrong_left--;
         end
      end
   endtask

   task automatic step(input stim_t s);
      bit acc;
      @(posedge clk);
      apply_model();
      #1;
      reset = s.rst; exeValid_i = s.exe; pc_i = s.pc; result_i = s.res;
      nextPC_i = s.npc; direction_i = s.dir; flags_i = s.flags;
      destValid_i = s.dv; phyDest_i = s.pd; robID_i = s.rob;
      flush_i = s.flush; updReady_i = s.rdy;
      acc = s.exe && s.flags[2] && !s.flush && !s.rst && (wrong_left == 0);
      if (acc) begin
         wb_q.push_back('{cyc: cyc + 1, data: s.res, dv: s.dv, pd: s.pd, rob: s.rob, mp: s.flags[0]});
         if (s.flags[0]) rd_q.push_back('{cyc: cyc + 1, pc: s.npc});
      end
      cur = s;
      cur_acc = acc;
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".wbValid"}, wbValid_o, 0);
      check({tag, ".wbDestValid"}, wbDestValid_o, 0);
      check({tag, ".wbMispredict"}, wbMispredict_o, 0);
      check({tag, ".wbData"}, wbData_o, 0);
      check({tag, ".wbPhyDest"}, wbPhyDest_o, 0);
      check({tag, ".wbRobID"}, wbRobID_o, 0);
      check({tag, ".recoverValid"}, recoverValid_o, 0);
      check({tag, ".recoverPC"}, recoverPC_o, 0);
      check({tag, ".updValid"}, updValid_o, 0);
      check({tag, ".updPC"}, updPC_o, 0);
      check({tag, ".updTarget"}, updTarget_o, 0);
      check({tag, ".updDir"}, updDir_o, 0);
      check({tag, ".stall"}, stall_o, 0);
   endtask

   // Monitor: compares whatever the DUT presents against the scoreboard.
   always @(negedge clk) begin : monitor
      wb_exp_t e;
      rd_exp_t r;
      bp_upd_t u;
      if (mon_en) begin
         if (wb_q.size() > 0 && wb_q[0].cyc == cyc) begin
            e = wb_q.pop_front();
            check("wb_valid", wbValid_o, 1);
            check("wb_data", wbData_o, e.data);
            check("wb_dest_valid", wbDestValid_o, e.dv);
            check("wb_phy_dest", wbPhyDest_o, e.pd);
            check("wb_rob_id", wbRobID_o, e.rob);
            check("wb_mispredict", wbMispredict_o, e.mp);
         end else begin
            check("wb_valid_idle", wbValid_o, 0);
         end

         if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            r = rd_q.pop_front();
            check("recover_valid", recoverValid_o, 1);
            check("recover_pc_pulse", recoverPC_o, r.pc);
         end else begin
            check("recover_valid_idle", recoverValid_o, 0);
         end
         check("recover_pc_hold", recoverPC_o, m_rpc);

         check("stall", stall_o, (upd_q.size() >= DEPTH - 1) || (wrong_left != 0));

         check("upd_valid", updValid_o, upd_q.size() != 0);
         if (upd_q.size() != 0 && updReady_i) begin
            u = upd_q.pop_front();
            check("upd_pc", updPC_o, u.pc);
            check("upd_target", updTarget_o, u.target);
            check("upd_dir", updDir_o, u.dir);
         end
      end
   end

   initial begin : driver
      stim_t s;
      cur = idle(1'b0);
      cur.rst = 1'b1;

      // Power-on reset
      s = idle(1'b0);
      s.rst = 1'b1;
      repeat (3) step(s);
      step(idle(1'b0));
      @(negedge clk);
      check_reset("por");
      mon_en = 1'b1;

      // Correctly predicted BNE: one writeback, one training entry, no redirect
      step(mk(32'h1000, 32'h0, 32'h1008, 1'b0, 8'hA4, 1'b0, 1'b0));
      repeat (2) step(idle(1'b0));
      repeat (3) step(idle(1'b1));

      // Mispredicted BEQ followed by five valid packets: four are wrong-path
      step(mk(32'h2000, 32'h2004, 32'h2040, 1'b1, 8'hA5, 1'b0, 1'b1));
      for (int i = 0; i < 5; i++)
         step(mk(32'h2100 + 32'(i * 4), 32'h0, 32'h2200 + 32'(i * 8), 1'b0, 8'hA4, 1'b0, 1'b1));
      repeat (3) step(idle(1'b1));

      // JAL: link writeback, no training entry
      step(mk(32'h3000, 32'h3008, 32'h3010, 1'b1, 8'h94, 1'b1, 1'b1));
      repeat (2) step(idle(1'b1));

      // Three training packets with the consumer stalled, then release it
      for (int i = 0; i < 3; i++)
         step(mk(32'h4000 + 32'(i * 16), 32'h0, 32'h4100 + 32'(i * 16), 1'(i), 8'hA4, 1'b0, 1'b0));
      repeat (3) step(idle(1'b0));
      repeat (5) step(idle(1'b1));

      // Squash coincident with a mispredict: no redirect
      s = mk(32'h5000, 32'h0, 32'h5040, 1'b1, 8'hA5, 1'b0, 1'b1);
      s.flush = 1'b1;
      step(s);
      repeat (2) step(idle(1'b1));

      // Reset landing in the drain window
      step(mk(32'h6000, 32'h0, 32'h6080, 1'b0, 8'hA5, 1'b0, 1'b1));
      repeat (2) step(idle(1'b1));
      s = idle(1'b1);
      s.rst = 1'b1;
      step(s);
      step(idle(1'b1));
      @(negedge clk);
      check_reset("rst_drain");

      // Randomised traffic; upstream mostly honours stall_o
      for (int i = 0; i < 2000; i++) begin
         s = idle(1'($urandom_range(0, 1)));
         s.exe   = ($urandom_range(0, 9) < 6);
         s.pc    = {$urandom_range(0, 32'hFFFF), 2'b00};
         s.res   = $urandom;
         s.npc   = {$urandom_range(0, 32'hFFFF), 2'b00};
         s.dir   = 1'($urandom_range(0, 1));
         s.flags = 8'($urandom);
         s.flags[2] = ($urandom_range(0, 9) < 8);
         s.flags[0] = ($urandom_range(0, 9) < 2);
         s.dv    = 1'($urandom_range(0, 1));
         s.pd    = 7'($urandom);
         s.rob   = 7'($urandom);
         s.flush = ($urandom_range(0, 99) < 4);
         s.rst   = ($urandom_range(0, 199) == 0);
         if (stall_o && $urandom_range(0, 9) < 8) s.exe = 1'b0;
         step(s);
      end

      repeat (12) step(idle(1'b1));
      @(negedge clk);
      check("final_upd_empty", updValid_o, 0);
      check("final_stall", stall_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
